lvds_ser_tx: RTL and testbench

LVDS_SER_TX -- requirements
Module: lvds_ser_tx

---
 rtl/lvds_tx_pkg.sv | 9 +
 rtl/lvds_tx_bitsel.sv | 21 ++
 rtl/lvds_ser_tx.sv | 98 +++++++++
 tb/tb_lvds_ser_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// lvds_tx_pkg: shared state enum, phase width and parameter defaults for the LVDS serializer
package lvds_tx_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int PHASE_W = 2;
    localparam logic [PHASE_W-1:0] PHASE_PRE  = 2'd2;
    localparam logic [PHASE_W-1:0] PHASE_LAST = 2'd3;
    localparam logic [7:0] IDLE_WORD_DEF  = 8'h00;
    localparam logic [7:0] FRAME_WORD_DEF = 8'h0F;
endpackage

// File: rtl/lvds_tx_bitsel.sv
// lvds_tx_bitsel: picks the DDR bit pair for a phase from a word slipped s bits into its predecessor
// Ports: word/prev_word (current and previous word), s (slip offset), phase (0..3),
//        rise/fall (bit pair, rise bit precedes fall bit)
module lvds_tx_bitsel
    import lvds_tx_pkg::*;
(
    input  logic [7:0]         word,
    input  logic [7:0]         prev_word,
    input  logic [2:0]         s,
    input  logic [PHASE_W-1:0] phase,
    output logic               rise,
    output logic               fall
);
    logic [7:0] sel;
    // {prev_word[s-1:0], word[7:s]}; index 7-2p is {~p,1}, 6-2p is {~p,0}
    always_comb begin
        sel  = 8'({prev_word, word} >> s);
        rise = sel[{~phase, 1'b1}];
        fall = sel[{~phase, 1'b0}];
    end
endmodule

// File: rtl/lvds_ser_tx.sv
// lvds_ser_tx: 8-bit word serializer driving ODDR2 data/frame bit pairs and the DCO enable
// Ports: clk, reset (async, active-high), enable, in_data/in_valid/in_ready (word input),
//        slip (only when LVDS_TX_BITSLIP_EN is defined), dout_rise/dout_fall, frame_rise/frame_fall,
//        dco_en, word_cnt (wrapping), underflow_cnt (saturating)
module lvds_ser_tx
    import lvds_tx_pkg::*;
#(
    parameter logic [7:0] IDLE_WORD  = IDLE_WORD_DEF,
    parameter logic [7:0] FRAME_WORD = FRAME_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
`ifdef LVDS_TX_BITSLIP_EN
    input  logic        slip,
`endif
    output logic        in_ready,
    output logic        dout_rise,
    output logic        dout_fall,
    output logic        frame_rise,
    output logic        frame_fall,
    output logic        dco_en,
    output logic [15:0] word_cnt,
    output logic [15:0] underflow_cnt
);
    state_t             state, state_n;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [7:0]         word, prev_word, word_n, prev_n;
    logic [2:0]         s_n;
    logic               boundary, accept, run_n, d_rise, d_fall, f_rise, f_fall;
    // in_ready already holds the run decision for the boundary, so it drives the next state
    always_comb begin
        boundary = phase == PHASE_LAST;
        accept   = in_valid && in_ready;
        phase_n  = phase + PHASE_W'(1);
        state_n  = boundary ? (in_ready ? RUN : IDLE) : state;
        run_n    = state_n == RUN;
        word_n   = boundary ? (accept ? in_data : IDLE_WORD) : word;
        prev_n   = boundary ? word : prev_word;
    end
`ifdef LVDS_TX_BITSLIP_EN
    logic [2:0] s_cnt, s_act;
    // s_act freezes the offset per word, so a slip always lands on the following word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_cnt <= '0;
            s_act <= '0;
        end else begin
            s_cnt <= s_cnt + 3'(slip);
            s_act <= s_n;
        end
    end
    assign s_n = boundary ? s_cnt : s_act;
`else
    assign s_n = '0;
`endif
    // outputs are computed from next-cycle values so every output is a plain register
    lvds_tx_bitsel u_data (
        .word(word_n), .prev_word(prev_n), .s(s_n), .phase(phase_n), .rise(d_rise), .fall(d_fall)
    );
    lvds_tx_bitsel u_frame (
        .word(FRAME_WORD), .prev_word(FRAME_WORD), .s(3'd0), .phase(phase_n), .rise(f_rise), .fall(f_fall)
    );
    // enable is taken the cycle before the boundary so in_ready can be a registered output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            phase         <= '0;
            word          <= IDLE_WORD;
            prev_word     <= IDLE_WORD;
            in_ready      <= 1'b0;
            dco_en        <= 1'b0;
            dout_rise     <= 1'b0;
            dout_fall     <= 1'b0;
            frame_rise    <= 1'b0;
            frame_fall    <= 1'b0;
            word_cnt      <= '0;
            underflow_cnt <= '0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            word       <= word_n;
            prev_word  <= prev_n;
            in_ready   <= phase == PHASE_PRE && enable;
            dco_en     <= run_n;
            dout_rise  <= run_n && d_rise;
            dout_fall  <= run_n && d_fall;
            frame_rise <= run_n && f_rise;
            frame_fall <= run_n && f_fall;
            if (accept)
                word_cnt <= word_cnt + 16'd1;
            if (boundary && in_ready && !in_valid && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_lvds_ser_tx.sv
// tb_lvds_ser_tx: randomized self-checking bench for lvds_ser_tx against a word-level model
module tb_lvds_ser_tx;
    localparam logic [7:0] IDLE_W  = 8'h00;
    localparam logic [7:0] FRAME_W = 8'h0F;
`ifdef LVDS_TX_BITSLIP_EN
    localparam bit HAS_SLIP = 1'b1;
    logic slip = 1'b0;
`else
    localparam bit HAS_SLIP = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, dout_rise, dout_fall, frame_rise, frame_fall, dco_en;
    logic [15:0] word_cnt, underflow_cnt;
    int checks = 0, errors = 0;

    int mphase;
    bit mrun, mready, acc;
    logic [7:0] mcur, mprev, mser;
    logic [2:0] mslip;
    logic [15:0] mwc, muf;

    always #5 clk = ~clk;

    lvds_ser_tx dut (
        .clk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
`ifdef LVDS_TX_BITSLIP_EN
        .slip(slip),
`endif
        .in_ready(in_ready), .dout_rise(dout_rise), .dout_fall(dout_fall),
        .frame_rise(frame_rise), .frame_fall(frame_fall), .dco_en(dco_en),
        .word_cnt(word_cnt), .underflow_cnt(underflow_cnt)
    );

    function automatic logic [1:0] pair(input logic [7:0] w, input int p);
        logic [7:0] t;
        t = w >> (6 - 2 * p);
        return t[1:0];
    endfunction

    function automatic logic [37:0] obs();
        return {in_ready, dco_en, dout_rise, dout_fall, frame_rise, frame_fall, word_cnt, underflow_cnt};
    endfunction

    function automatic logic [37:0] expv();
        return {mready, mrun, mrun ? pair(mser, mphase) : 2'b00, mrun ? pair(FRAME_W, mphase) : 2'b00, mwc, muf};
    endfunction

    task automatic model_reset();
        mphase = 0; mrun = 0; mready = 0; acc = 0;
        mcur = IDLE_W; mprev = IDLE_W; mser = IDLE_W; mslip = 0; mwc = 0; muf = 0;
    endtask

    // one bit-pair cycle: drive at negedge, advance the word-level model at the edge, sample 1 after
    task automatic cyc(input bit en, input bit v, input logic [7:0] d, input bit sl);
        @(negedge clk);
        enable = en; in_valid = v; in_data = d;
`ifdef LVDS_TX_BITSLIP_EN
        slip = sl;
`endif
        @(posedge clk);
        acc = 0;
        if (mphase == 3) begin
            mrun  = mready;
            mprev = mcur;
            acc   = mready && v;
            mcur  = acc ? d : IDLE_W;
            if (acc) mwc++;
            else if (mready && muf != 16'hFFFF) muf++;
            mser = 8'({mprev, mcur} >> mslip);
        end
        if (sl) mslip++;
        mready = (mphase == 2) && en;
        mphase = (mphase + 1) % 4;
        #1;
    endtask

    task automatic do_reset();
        enable = 0; in_valid = 0;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        model_reset();
    endtask

    task automatic wait_accept(input logic [7:0] d, output bit ok);
        logic [15:0] wc0;
        wc0 = word_cnt;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            cyc(1, 1, d, 0);
            ok = word_cnt !== wc0;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (obs() !== 38'd0) begin errors++; $display("FAIL reset_hold got %h want 0", obs()); end
        @(posedge clk); #1 reset = 0;
        model_reset();
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL reset_release got %h want %h", obs(), expv()); end
    endtask

    task automatic test_idle_run();
        logic [7:0] frm, dat;
        frm = 0; dat = 0;
        for (int i = 0; i < 27; i++) begin
            cyc(1, 0, 8'h00, 0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL idle_run cycle %0d got %h want %h", i, obs(), expv()); end
            if (i >= 23) begin
                frm = {frm[5:0], frame_rise, frame_fall};
                dat = {dat[5:0], dout_rise, dout_fall};
            end
        end
        checks++;
        if (frm !== 8'h0F) begin errors++; $display("FAIL idle_run frame got %h want 0f", frm); end
        checks++;
        if (dat !== 8'h00) begin errors++; $display("FAIL idle_run data got %h want 00", dat); end
        checks++;
        if (underflow_cnt !== 16'd6) begin errors++; $display("FAIL idle_run underflow got %0d want 6", underflow_cnt); end
    endtask

    task automatic test_single_word();
        bit ok;
        logic [7:0] got;
        do_reset();
        wait_accept(8'hA5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single accept timed out word_cnt %0d want 1", word_cnt); end
        got = {6'd0, dout_rise, dout_fall};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL single cycle %0d got %h want %h", i, obs(), expv()); end
            if (i < 3) begin
                cyc(1, 0, 8'h00, 0);
                got = {got[5:0], dout_rise, dout_fall};
            end
        end
        checks++;
        if (got !== 8'hA5) begin errors++; $display("FAIL single pairs got %h want a5", got); end
        checks++;
        if (word_cnt !== 16'd1) begin errors++; $display("FAIL single word_cnt got %0d want 1", word_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] got;
        do_reset();
        wait_accept(8'h12, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b accept timed out word_cnt %0d want 1", word_cnt); end
        got = {14'd0, dout_rise, dout_fall};
        for (int i = 1; i < 8; i++) begin
            cyc(1, i <= 4, 8'h34, 0);
            got = {got[13:0], dout_rise, dout_fall};
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL b2b cycle %0d got %h want %h", i, obs(), expv()); end
        end
        checks++;
        if (got !== 16'h1234) begin errors++; $display("FAIL b2b stream got %h want 1234", got); end
        checks++;
        if (underflow_cnt !== 16'd0 || word_cnt !== 16'd2) begin
            errors++; $display("FAIL b2b counters got %0d/%0d want 2/0", word_cnt, underflow_cnt);
        end
    endtask

    task automatic test_enable_drop();
        bit ok, rdy;
        int dcnt;
        logic [15:0] wc0;
        wait_accept(8'h5A, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drop accept timed out"); end
        cyc(1, 0, 8'h00, 0);
        wc0 = word_cnt; dcnt = 0; rdy = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 8'hC3, 0);
            dcnt += int'(dco_en);
            rdy |= in_ready;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL drop cycle %0d got %h want %h", i, obs(), expv()); end
        end
        checks++;
        if (dcnt !== 2) begin errors++; $display("FAIL drop dco_en cycles got %0d want 2", dcnt); end
        checks++;
        if (rdy !== 1'b0 || word_cnt !== wc0) begin
            errors++; $display("FAIL drop ready/word_cnt got %b/%0d want 0/%0d", rdy, word_cnt, wc0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_accept(8'hFF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid accept timed out"); end
        cyc(1, 0, 8'h00, 0);
        cyc(1, 0, 8'h00, 0);
        checks++;
        if ({dco_en, dout_rise, dout_fall} !== 3'b111) begin
            errors++; $display("FAIL rst_mid phase2 got %b want 111", {dco_en, dout_rise, dout_fall});
        end
        #2 reset = 1;
        #1;
        checks++;
        if (obs() !== 38'd0) begin errors++; $display("FAIL rst_mid async got %h want 0", obs()); end
        @(posedge clk); #1 reset = 0;
        model_reset();
        for (int k = 1; k <= 6; k++) begin
            cyc(1, 0, 8'h00, 0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL rst_mid cycle %0d got %h want %h", k, obs(), expv()); end
            if (k == 3 || k == 4) begin
                checks++;
                if (dco_en !== (k == 4)) begin errors++; $display("FAIL rst_mid run start cycle %0d dco_en got %b", k, dco_en); end
            end
        end
    endtask

    task automatic test_random();
        bit en;
        en = 1;
        for (int i = 0; i < 400; i++) begin
            if (mphase <= 1 && $urandom_range(0, 9) == 0) en = ~en;
            cyc(en, $urandom_range(0, 9) < 6, 8'($urandom), HAS_SLIP && $urandom_range(0, 15) == 0);
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random cycle %0d got %h want %h", i, obs(), expv()); end
        end
    endtask

`ifdef LVDS_TX_BITSLIP_EN
    task automatic test_bitslip();
        bit ok;
        logic [7:0] got;
        do_reset();
        cyc(1, 0, 8'h00, 1);
        wait_accept(8'hF0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL slip accept timed out"); end
        got = 0;
        for (int i = 1; i < 8; i++) begin
            cyc(1, i <= 4, 8'h0F, 0);
            if (i >= 4) got = {got[5:0], dout_rise, dout_fall};
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL slip cycle %0d got %h want %h", i, obs(), expv()); end
        end
        checks++;
        if (got !== 8'h07) begin errors++; $display("FAIL slip word got %h want 07", got); end
        for (int i = 0; i < 7; i++) cyc(1, 0, 8'h00, 1);
        wait_accept(8'h3C, ok);
        got = {6'd0, dout_rise, dout_fall};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h00, 0);
            got = {got[5:0], dout_rise, dout_fall};
        end
        checks++;
        if (got !== 8'h3C) begin errors++; $display("FAIL slip restore got %h want 3c", got); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_idle_run();
        test_single_word();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
`ifdef LVDS_TX_BITSLIP_EN
        test_bitslip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
